// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of the CPU data-memory interface.
// Accepts one load/store at a time from the MEM stage and drives a word-wide
// data memory. Sub-word loads are extracted and sign/zero-extended; sub-word
// stores are done as read-modify-write. Misaligned/out-of-range/illegal-size
// requests complete with err=1 and never touch memory.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   req             request strobe, sampled only in IDLE
//   memOp           [3]=store, [2]=unsigned load, [1:0]=size (byte/half/word)
//   addr, storeData byte address and store operand
//   busy, done, err handshake back to the pipeline
//   loadData        load result, held until the next done
//   memCe, memWe, memAddr, memWdata, memRdata   data memory interface
module mem_access_unit #(
   parameter int unsigned MEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [3:0]  memOp,
   input  logic [31:0] addr,
   input  logic [31:0] storeData,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] loadData,
   output logic        memCe,
   output logic        memWe,
   output logic [31:0] memAddr,
   output logic [31:0] memWdata,
   input  logic [31:0] memRdata
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_WRITE  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   // 34 bits so a large MEM_WORDS cannot wrap the byte limit
   localparam logic [33:0] ADDR_LIMIT = 34'(MEM_WORDS) << 2;

   logic [1:0]  r_state;
   logic [3:0]  r_op;
   logic [31:0] r_addr;
   logic [31:0] r_sdata;
   logic        r_err;
   logic [31:0] r_load_data;
   logic [31:0] r_merged;

   logic        w_illegal;
   logic        w_store;
   logic        w_word;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_merged;

   assign w_illegal = (memOp[1:0] == SZ_ILL)
                    | ((memOp[1:0] == SZ_HALF) & addr[0])
                    | ((memOp[1:0] == SZ_WORD) & (addr[1:0] != 2'b00))
                    | ({2'b00, addr} >= ADDR_LIMIT);

   assign w_store = r_op[3];
   assign w_word  = (r_op[1:0] == SZ_WORD);

   // Little-endian lane extraction from the word currently on memRdata
   always_comb begin
      w_byte = memRdata[7:0];
      unique case (r_addr[1:0])
         2'd0: w_byte = memRdata[7:0];
         2'd1: w_byte = memRdata[15:8];
         2'd2: w_byte = memRdata[23:16];
         2'd3: w_byte = memRdata[31:24];
         default: w_byte = memRdata[7:0];
      endcase
   end

   assign w_half = r_addr[1] ? memRdata[31:16] : memRdata[15:0];

   always_comb begin
      w_load = memRdata;
      if (r_op[1:0] == SZ_BYTE) begin
         w_load = {{24{~r_op[2] & w_byte[7]}}, w_byte};
      end else if (r_op[1:0] == SZ_HALF) begin
         w_load = {{16{~r_op[2] & w_half[15]}}, w_half};
      end
   end

   // Read-modify-write merge: replace only the addressed lane
   always_comb begin
      w_merged = memRdata;
      if (r_op[1:0] == SZ_BYTE) begin
         unique case (r_addr[1:0])
            2'd0: w_merged[7:0]   = r_sdata[7:0];
            2'd1: w_merged[15:8]  = r_sdata[7:0];
            2'd2: w_merged[23:16] = r_sdata[7:0];
            2'd3: w_merged[31:24] = r_sdata[7:0];
            default: w_merged = memRdata;
         endcase
      end else if (r_op[1:0] == SZ_HALF) begin
         if (r_addr[1]) w_merged[31:16] = r_sdata[15:0];
         else           w_merged[15:0]  = r_sdata[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_op        <= 4'd0;
         r_addr      <= 32'd0;
         r_sdata     <= 32'd0;
         r_err       <= 1'b0;
         r_load_data <= 32'd0;
         r_merged    <= 32'd0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_op    <= memOp;
                  r_addr  <= addr;
                  r_sdata <= storeData;
                  r_err   <= w_illegal;
                  r_state <= w_illegal ? S_DONE : S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (!w_store) begin
                  r_load_data <= w_load;
                  r_state     <= S_DONE;
               end else if (w_word) begin
                  r_state <= S_DONE;
               end else begin
                  r_merged <= w_merged;
                  r_state  <= S_WRITE;
               end
            end
            S_WRITE: r_state <= S_DONE;
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Memory-side outputs decode state only, so reset removes them at once
   assign memCe    = (r_state == S_ACCESS) | (r_state == S_WRITE);
   assign memWe    = ((r_state == S_ACCESS) & w_store & w_word) | (r_state == S_WRITE);
   assign memAddr  = memCe ? {r_addr[31:2], 2'b00} : 32'd0;
   assign memWdata = (r_state == S_WRITE) ? r_merged : (memWe ? r_sdata : 32'd0);

   assign busy     = (r_state != S_IDLE);
   assign done     = (r_state == S_DONE);
   assign err      = done & r_err;
   assign loadData = r_load_data;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the CPU data-memory interface. It sits between the MEM pipeline stage and the data memory.
- It accepts one load/store request at a time and drives the word-wide data memory's chip-enable, write-enable, address and write-data lines.
- Sub-word loads are extracted and extended. Sub-word stores are performed as read-modify-write, because the data memory writes whole words only.
- Misaligned and out-of-range accesses are flagged and never reach memory.

Parameters:
- MEM_WORDS, 1024: data memory depth in 32-bit words. An access is legal only if addr < 4*MEM_WORDS.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only in IDLE.
- memOp  in  4  bit3 = store, bit2 = unsigned load, bits[1:0] = size (00 byte, 01 half, 10 word, 11 illegal).
- addr  in  32  byte address.
- storeData  in  32  store operand; byte/half taken from its low bits.
- busy  out  1  high whenever state != IDLE; the pipeline stalls on it.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: misaligned, out-of-range or illegal size.
- loadData  out  32  load result; valid with done and held until the next done.
- memCe  out  1  data memory chip enable.
- memWe  out  1  data memory write enable.
- memAddr  out  32  word address; bits[1:0] always 0.
- memWdata  out  32  word to be written.
- memRdata  in  32  data memory read data; combinational, valid in the same cycle as memCe.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, done=0, err=0, loadData=0, memCe=0, memWe=0, memAddr=0, memWdata=0.
  - Memory outputs are Moore decodes of state, so memCe/memWe drop immediately on reset, including mid-operation.
  - An in-flight access is abandoned. A partial RMW never writes.
- States: IDLE, ACCESS, WRITE, DONE.
- IDLE:
  - If req=1 at a rising edge: latch memOp, addr, storeData.
  - Check the request:
    - Illegal if size=11.
    - Illegal if half with addr[0]=1.
    - Illegal if word with addr[1:0]!=0.
    - Illegal if addr >= 4*MEM_WORDS.
  - Illegal request → DONE with err=1. No memory cycle occurs.
  - Legal request → ACCESS.
  - req=0 → stay in IDLE.
- ACCESS:
  - memCe=1, memAddr={addr[31:2],2'b00}.
  - Load:
    - memWe=0. Capture the extracted lane of memRdata into loadData at the edge → DONE.
    - Extraction is little-endian: byte k = memRdata[8k+7:8k] with k=addr[1:0]; half = memRdata[16h+15:16h] with h=addr[1].
    - Sign-extend unless memOp[2]=1, in which case zero-extend.
  - Word store: memWe=1, memWdata=storeData; the memory writes at the edge → DONE.
  - Sub-word store:
    - memWe=0. Register the merged word = memRdata with the target lane replaced by storeData[7:0] or storeData[15:0] → WRITE.
    - memOp[2] is ignored for stores.
- WRITE: memCe=1, memWe=1, same memAddr, memWdata=merged word → DONE.
- DONE:
  - done=1 for exactly one cycle; memCe=0, memWe=0; err is as decided in IDLE.
  - Next state IDLE unconditionally. A req in this cycle is ignored.
  - Earliest next acceptance is the edge ending the following IDLE cycle.
- Latency, from the accepting edge to the done pulse:
  - Load and word store: done in cycle 2.
  - Sub-word store: done in cycle 3.
  - Error: done in cycle 1.
  - Throughput is one access per 3 cycles, or 4 for sub-word stores.
- memCe=0 in IDLE and DONE. memWe=1 only in ACCESS (word store) or WRITE. memWdata=0 whenever memWe=0.
- loadData is unchanged by stores and errors.
- Inputs are not sampled while busy=1. Changes to req, addr, memOp or storeData while busy have no effect.

Test Plan:
- Memory word 0x40 preset to 0x8899AABB; LB from 0x41 → done in 2 cycles, loadData=0xFFFFFFAA, err=0. LBU from 0x41 → 0x000000AA.
- LH from 0x42 → loadData=0xFFFF8899. LHU from 0x42 → 0x00008899. LW from 0x40 → 0x8899AABB.
- SB of storeData 0x12345677 to 0x43 with word 0x40 = 0x8899AABB → one read cycle then one write cycle; memory word becomes 0x7799AABB; done in cycle 3; exactly one memWe pulse.
- SW of 0xDEADBEEF to 0x10 → memWe high for one cycle with memAddr=0x10; memory word = 0xDEADBEEF; done in cycle 2.
- Error cases:
  - LW at 0x02 → done in cycle 1 with err=1.
  - SH at 0x01 → done in cycle 1 with err=1.
  - LW at 0x1000 (MEM_WORDS=1024) → done in cycle 1 with err=1.
  - memOp size=11 → done in cycle 1 with err=1.
  - In all four, memCe stays 0 and loadData is unchanged.
- SH of 0xBEEF to 0x22: assert rst=0 during WRITE → memCe/memWe drop immediately; memory word 0x20 is unchanged; after rst=1, busy=0, and a new LW at 0x20 returns the original value.
